// File: rtl/md_scheduler_if.sv
// Handshake/data bundle between the EX stage and the multiply/divide unit.
// master: EX/ID side drives op requests; slave: md unit returns busy/stall/hi/lo.
interface md_scheduler_if;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        id_md_use;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, md_op, src_a, src_b, flush, id_md_use,
        input  busy, stall_req, hi, lo
    );

    modport slave (
        input  start, md_op, src_a, src_b, flush, id_md_use,
        output busy, stall_req, hi, lo
    );
endinterface

// File: rtl/md_scheduler.sv
// Multi-cycle MULT/DIV unit with HI/LO registers and ID stall request.
// Ports: clk, rst_n (async low), md (slave modport: op in, busy/stall/hi/lo out).
module md_scheduler #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    md_scheduler_if.slave md
);
    localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [31:0]   hi_q, lo_q;
    logic [31:0]   pend_hi, pend_lo;
    logic          pend_ok;
    logic          issue, commit, mt_hi, mt_lo;

    logic          is_md;
    logic [31:0]   res_hi, res_lo;
    logic          res_ok;

    assign is_md        = ~md.md_op[2];
    assign md.busy      = (state == RUN);
    assign md.stall_req = md.id_md_use & (md.busy | (md.start & is_md));
    assign md.hi        = hi_q;
    assign md.lo        = lo_q;

    // Result is computed at issue from the operands of that cycle only.
    logic signed [63:0] sa, sb;
    logic [63:0]        prod;
    logic               sdiv, neg_a, neg_b;
    logic [31:0]        ma, mb, dv, q, r;

    always_comb begin
        sa     = signed'({{32{md.src_a[31]}}, md.src_a});
        sb     = signed'({{32{md.src_b[31]}}, md.src_b});
        prod   = 64'd0;
        sdiv   = (md.md_op == 3'd2);
        neg_a  = sdiv & md.src_a[31];
        neg_b  = sdiv & md.src_b[31];
        ma     = neg_a ? (32'd0 - md.src_a) : md.src_a;
        mb     = neg_b ? (32'd0 - md.src_b) : md.src_b;
        // Divisor 0 is swapped for 1 only to keep the divider defined;
        // the result is discarded via res_ok.
        dv     = (mb == 32'd0) ? 32'd1 : mb;
        q      = ma / dv;
        r      = ma % dv;
        res_hi = 32'd0;
        res_lo = 32'd0;
        res_ok = 1'b1;
        unique case (md.md_op[1:0])
            2'd0: prod = 64'(sa * sb);
            2'd1: prod = {32'd0, md.src_a} * {32'd0, md.src_b};
            default: prod = 64'd0;
        endcase
        if (md.md_op[1]) begin
            res_lo = (neg_a ^ neg_b) ? (32'd0 - q) : q;
            res_hi = neg_a ? (32'd0 - r) : r;
            res_ok = (md.src_b != 32'd0);
        end else begin
            res_hi = prod[63:32];
            res_lo = prod[31:0];
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        issue   = 1'b0;
        commit  = 1'b0;
        mt_hi   = 1'b0;
        mt_lo   = 1'b0;
        unique case (state)
            IDLE: begin
                if (md.start && !md.flush) begin
                    if (is_md) begin
                        issue   = 1'b1;
                        state_n = RUN;
                        cnt_n   = md.md_op[1] ? CW'(DIV_CYCLES)
                                              : CW'(MUL_CYCLES);
                    end else begin
                        mt_hi = (md.md_op == 3'd4);
                        mt_lo = (md.md_op == 3'd5);
                    end
                end
            end
            RUN: begin
                if (md.flush) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt == CW'(1)) begin
                    commit  = pend_ok;
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_ok <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (issue) begin
                pend_hi <= res_hi;
                pend_lo <= res_lo;
                pend_ok <= res_ok;
            end
            if (commit) begin
                hi_q <= pend_hi;
                lo_q <= pend_lo;
            end
            if (mt_hi) hi_q <= md.src_a;
            if (mt_lo) lo_q <= md.src_a;
        end
    end
endmodule

// File: tb/tb_md_scheduler.sv
// Self-checking bench for md_scheduler: vector table plus scoreboard,
// with hand sequences for stall, flush, MT ops and mid-op reset.
module tb_md_scheduler;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    md_scheduler_if bus();

    md_scheduler #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .md    (bus.slave)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
        string       name;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int total = 0;
    int bad = 0;
    logic [31:0] prev_hi, prev_lo;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        bus.start = 1'b1;
        bus.md_op = op;
        bus.src_a = a;
        bus.src_b = b;
        tick();
        bus.start = 1'b0;
        bus.md_op = 3'd7;
        bus.src_a = $urandom;
        bus.src_b = $urandom;
    endtask

    // Issue a vector, count busy cycles, then compare with the popped expectation.
    task automatic run_vec(input vec_t v);
        exp_t e;
        int n;
        sb_q.push_back('{v.hi, v.lo, v.cyc, v.name});
        prev_hi = bus.hi;
        prev_lo = bus.lo;
        do_op(v.op, v.a, v.b);
        n = 0;
        forever begin
            @(negedge clk);
            if (!bus.busy || n >= 60) break;
            n++;
            if (n == 1)
                check({v.name, " hold"}, {bus.hi, bus.lo}, {prev_hi, prev_lo});
            tick();
        end
        e = sb_q.pop_front();
        check({e.name, " timeout"}, 64'(bus.busy), 64'd0);
        check({e.name, " cycles"}, 64'(n), 64'(e.cyc));
        check({e.name, " hilo"}, {bus.hi, bus.lo}, {e.hi, e.lo});
        tick();
    endtask

    vec_t vt[8];

    initial begin
        int n;
        vt[0] = '{3'd0, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5, "mult"};
        vt[1] = '{3'd1, 32'hFFFF_FFFE, 32'd3, 32'h2, 32'hFFFF_FFFA, 5, "multu"};
        vt[2] = '{3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, "div_neg"};
        vt[3] = '{3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 10, "divu"};
        vt[4] = '{3'd2, 32'd5, 32'd0, 32'd2, 32'd14, 10, "div_zero"};
        vt[5] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 10, "div_ovf"};
        vt[6] = '{3'd0, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, 5, "mult_big"};
        vt[7] = '{3'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 10, "div_negb"};

        bus.start = 0; bus.md_op = 3'd7; bus.src_a = 0; bus.src_b = 0;
        bus.flush = 0; bus.id_md_use = 0;
        #12;
        check("rst busy", 64'(bus.busy), 64'd0);
        check("rst hilo", {bus.hi, bus.lo}, 64'd0);
        check("rst stall", 64'(bus.stall_req), 64'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) run_vec(vt[i]);

        // Stall while MFLO sits in ID.
        bus.id_md_use = 1'b1;
        bus.start = 1'b1; bus.md_op = 3'd2; bus.src_a = 32'd50; bus.src_b = 32'd7;
        #1;
        check("stall issue", 64'(bus.stall_req), 64'd1);
        tick();
        bus.start = 0; bus.md_op = 3'd7;
        n = 0;
        forever begin
            @(negedge clk);
            if (!bus.busy || n >= 60) break;
            if (bus.stall_req) n++;
            tick();
        end
        check("stall cycles", 64'(n), 64'd10);
        check("stall idle", 64'(bus.stall_req), 64'd0);
        check("mflo quot", {bus.hi, bus.lo}, {32'd1, 32'd7});
        tick();

        // Same op without an ID consumer never stalls.
        bus.id_md_use = 1'b0;
        bus.start = 1'b1; bus.md_op = 3'd2; bus.src_a = 32'd9; bus.src_b = 32'd2;
        #1;
        n = (bus.stall_req) ? 1 : 0;
        tick();
        bus.start = 0; bus.md_op = 3'd7;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            if (bus.stall_req) n++;
            tick();
        end
        check("no stall", 64'(n), 64'd0);
        check("div 9/2", {bus.hi, bus.lo}, {32'd1, 32'd4});

        // Flush in busy cycle 2 drops the MULT.
        do_op(3'd1, 32'd6, 32'd6);
        tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("flush busy", 64'(bus.busy), 64'd0);
        for (int i = 0; i < 6; i++) tick();
        check("flush hilo", {bus.hi, bus.lo}, {32'd1, 32'd4});

        // Flush with a same-cycle start blocks the issue.
        bus.flush = 1'b1;
        do_op(3'd0, 32'd3, 32'd3);
        bus.flush = 1'b0;
        check("flush start", 64'(bus.busy), 64'd0);

        // Back-to-back MTHI/MTLO.
        n = 0;
        do_op(3'd4, 32'h1234, 32'd0);
        if (bus.busy) n++;
        do_op(3'd5, 32'h5678, 32'd0);
        if (bus.busy) n++;
        check("mt busy", 64'(n), 64'd0);
        check("mt hilo", {bus.hi, bus.lo}, {32'h1234, 32'h5678});

        // No-op code leaves state alone.
        do_op(3'd6, 32'hDEAD, 32'hBEEF);
        check("nop", {31'd0, bus.busy, bus.hi, bus.lo}, {32'd0, 32'h1234, 32'h5678});

        // Asynchronous reset in cycle 3 of a DIV.
        do_op(3'd2, 32'd9, 32'd3);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("rst mid busy", 64'(bus.busy), 64'd0);
        check("rst mid hilo", {bus.hi, bus.lo}, 64'd0);
        #2;
        rst_n = 1'b1;
        tick();
        vt[0] = '{3'd1, 32'd3, 32'd4, 32'd0, 32'd12, 5, "after_rst"};
        run_vec(vt[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
